// File: rtl/common_pkg.sv
// Shared types for the memory stage: execute/memory bundles, memory op set,
// bus size encodings, FSM states and op-classification helpers.
package common;

  typedef enum logic [3:0] {
    OP_NONE, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } mem_op_t;

  typedef struct packed {
    mem_op_t    mem_op;
    logic       regwrite;
    logic       csr_we;
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] mem_addr;
    logic [11:0] csr_addr;
    logic [63:0] csr_result;
    logic        stall;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [11:0] csr_addr;
    logic [63:0] csr_result;
    logic        misalign;
  } memory_data_t;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

  function automatic logic is_load(input mem_op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic [2:0] op_size(input mem_op_t op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return MSIZE2;
      OP_LW, OP_LWU, OP_SW: return MSIZE4;
      OP_LD, OP_SD:         return MSIZE8;
      default:              return MSIZE1;
    endcase
  endfunction

  function automatic logic misaligned(input mem_op_t op, input logic [2:0] a);
    case (op_size(op))
      MSIZE2:  return a[0];
      MSIZE4:  return a[1:0] != 2'b00;
      MSIZE8:  return a != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_lane.sv
// Byte-lane steering for the memory stage: store strobe/data shifting and
// load extraction with sign or zero extension. Purely combinational.
module mem_lane
  import common::*;
#(
  parameter int DATA_W = 64
) (
  input  mem_op_t           op,
  input  logic [2:0]        offset,
  input  logic [DATA_W-1:0] store_val,
  input  logic [DATA_W-1:0] load_word,
  output logic [2:0]        size,
  output logic [7:0]        strobe,
  output logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_val
);

  logic [DATA_W-1:0]        shifted;
  logic signed [7:0]        byte_s;
  logic signed [15:0]       half_s;
  logic signed [31:0]       word_s;
  logic signed [DATA_W-1:0] ext_s;

  always_comb begin
    size       = op_size(op);
    strobe     = 8'h00;
    store_data = '0;
    if (is_store(op)) begin
      store_data = store_val << {offset, 3'b000};
      case (size)
        MSIZE1:  strobe = 8'h01 << offset;
        MSIZE2:  strobe = 8'h03 << offset;
        MSIZE4:  strobe = 8'h0F << offset;
        default: strobe = 8'hFF;
      endcase
    end
  end

  // Load path: bring the addressed byte to lane 0, then extend per op.
  always_comb begin
    shifted  = load_word >> {offset, 3'b000};
    byte_s   = shifted[7:0];
    half_s   = shifted[15:0];
    word_s   = shifted[31:0];
    ext_s    = '0;
    load_val = '0;
    case (op)
      OP_LB:   begin ext_s = byte_s; load_val = ext_s; end
      OP_LH:   begin ext_s = half_s; load_val = ext_s; end
      OP_LW:   begin ext_s = word_s; load_val = ext_s; end
      OP_LBU:  load_val = DATA_W'(shifted[7:0]);
      OP_LHU:  load_val = DATA_W'(shifted[15:0]);
      OP_LWU:  load_val = DATA_W'(shifted[31:0]);
      OP_LD:   load_val = shifted;
      default: load_val = '0;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues data-bus requests for loads/stores, stalls upstream while
// a transaction is outstanding. MEM_MISALIGN_CHECK_EN enables misalign trapping.
module memory_access
  import common::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  execute_data_t     dataE,
  input  logic              valid_e,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output memory_data_t      dataM,
  output logic              valid_m,
  output logic              stall_m
);

  mem_state_t        state, state_nxt;
  memory_data_t      cap;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] load_val;
  logic              live, mem_e, mis_e, accept_mem, done;

  assign live  = valid_e & ~dataE.stall;
  assign mem_e = is_load(dataE.ctl.mem_op) | is_store(dataE.ctl.mem_op);
`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_e = mem_e & misaligned(dataE.ctl.mem_op, dataE.mem_addr[2:0]);
`else
  assign mis_e = 1'b0;
`endif
  assign accept_mem = (state == IDLE) & live & mem_e & ~mis_e;
  assign done = ((state == REQ) & dresp_addr_ok & dresp_data_ok) |
                ((state == WAIT) & dresp_data_ok);

  always_comb begin
    state_nxt = state;
    stall_m   = 1'b0;
    case (state)
      IDLE: begin
        if (accept_mem) begin
          state_nxt = REQ;
          stall_m   = 1'b1;
        end
      end
      REQ: begin
        stall_m = ~done;
        if (done)               state_nxt = IDLE;
        else if (dresp_addr_ok) state_nxt = WAIT;
      end
      WAIT: begin
        stall_m = ~done;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dreq_valid = (state == REQ);
  assign dreq_addr  = cap_addr;

  mem_lane #(.DATA_W(DATA_W)) u_lane (
    .op         (cap.ctl.mem_op),
    .offset     (cap_addr[2:0]),
    .store_val  (cap.result[DATA_W-1:0]),
    .load_word  (dresp_data),
    .size       (dreq_size),
    .strobe     (dreq_strobe),
    .store_data (dreq_data),
    .load_val   (load_val)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request capture: held stable for the whole bus transaction.
  always_ff @(posedge clk) begin
    if (accept_mem) begin
      cap.pc         <= dataE.pc;
      cap.ctl        <= dataE.ctl;
      cap.dst        <= dataE.dst;
      cap.result     <= dataE.result;
      cap.csr_addr   <= dataE.csr_addr;
      cap.csr_result <= dataE.csr_result;
      cap.misalign   <= 1'b0;
      cap_addr       <= dataE.mem_addr[ADDR_W-1:0];
    end
  end

  // Writeback register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_m <= 1'b0;
      dataM   <= '0;
    end else begin
      valid_m <= 1'b0;
      if (done) begin
        valid_m      <= 1'b1;
        dataM        <= cap;
        dataM.result <= is_load(cap.ctl.mem_op) ? 64'(load_val) : 64'd0;
      end else if ((state == IDLE) && live && (!mem_e || mis_e)) begin
        valid_m          <= 1'b1;
        dataM.pc         <= dataE.pc;
        dataM.ctl        <= dataE.ctl;
        dataM.dst        <= dataE.dst;
        dataM.result     <= mis_e ? 64'd0 : dataE.result;
        dataM.csr_addr   <= dataE.csr_addr;
        dataM.csr_result <= dataE.csr_result;
        dataM.misalign   <= mis_e;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: table of single-cycle load/store transactions
// plus hand-written sequences for stalls, reset mid-transaction and misalign.
module tb_memory_access;
  import common::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  logic          valid_e;
  logic          dreq_valid;
  logic [63:0]   dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [63:0]   dreq_data;
  logic          dresp_addr_ok, dresp_data_ok;
  logic [63:0]   dresp_data;
  memory_data_t  dataM;
  logic          valid_m, stall_m;

  int n_chk = 0;
  int n_fail = 0;

  memory_access #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .dataE(dataE), .valid_e(valid_e),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .dataM(dataM), .valid_m(valid_m), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    mem_op_t     op;
    logic [63:0] addr;
    logic [63:0] wval;
    logic [63:0] rdata;
    logic [63:0] exp_res;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_strobe;
    logic [2:0]  exp_size;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input mem_op_t op, input logic [63:0] addr, input logic [63:0] val);
    dataE            = '0;
    dataE.pc         = 64'h8000_0000 + addr;
    dataE.ctl.mem_op = op;
    dataE.ctl.regwrite = is_load(op) || (op == OP_NONE);
    dataE.dst        = 5'd7;
    dataE.mem_addr   = addr;
    dataE.result     = val;
    valid_e          = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    present(v.op, v.addr, v.wval);
    #1 check({v.name, " stall_idle"}, 64'(stall_m), 64'd1);
    tick();
    check({v.name, " dreq_valid"}, 64'(dreq_valid), 64'd1);
    check({v.name, " addr"}, dreq_addr, v.addr);
    check({v.name, " size"}, 64'(dreq_size), 64'(v.exp_size));
    check({v.name, " strobe"}, 64'(dreq_strobe), 64'(v.exp_strobe));
    check({v.name, " wdata"}, dreq_data, v.exp_wdata);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = v.rdata;
    #1 check({v.name, " stall_done"}, 64'(stall_m), 64'd0);
    tick();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    valid_e       = 1'b0;
    check({v.name, " valid_m"}, 64'(valid_m), 64'd1);
    check({v.name, " result"}, dataM.result, v.exp_res);
    #1 check({v.name, " idle_after"}, 64'(stall_m | dreq_valid), 64'd0);
    tick();
    check({v.name, " valid_m_pulse"}, 64'(valid_m), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{"LB",  OP_LB,  64'h2005, 64'h0, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 64'h0, 8'h00, MSIZE1};
    vecs[1]  = '{"LBU", OP_LBU, 64'h2005, 64'h0, 64'h0000_8000_0000_0000, 64'h0000_0000_0000_0080, 64'h0, 8'h00, MSIZE1};
    vecs[2]  = '{"LW",  OP_LW,  64'h3004, 64'h0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 64'h0, 8'h00, MSIZE4};
    vecs[3]  = '{"LWU", OP_LWU, 64'h3004, 64'h0, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 64'h0, 8'h00, MSIZE4};
    vecs[4]  = '{"LH",  OP_LH,  64'h2002, 64'h0, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D, 64'h0, 8'h00, MSIZE2};
    vecs[5]  = '{"LHU", OP_LHU, 64'h2002, 64'h0, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D, 64'h0, 8'h00, MSIZE2};
    vecs[6]  = '{"LD",  OP_LD,  64'h5000, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h0, 8'h00, MSIZE8};
    vecs[7]  = '{"SH",  OP_SH,  64'h1006, 64'hBEEF, 64'h0, 64'h0, 64'hBEEF_0000_0000_0000, 8'hC0, MSIZE2};
    vecs[8]  = '{"SW",  OP_SW,  64'h1004, 64'h1122_3344, 64'h0, 64'h0, 64'h1122_3344_0000_0000, 8'hF0, MSIZE4};
    vecs[9]  = '{"SD",  OP_SD,  64'h1000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, MSIZE8};
    vecs[10] = '{"SB",  OP_SB,  64'h1001, 64'h5A, 64'h0, 64'h0, 64'h0000_0000_0000_5A00, 8'h02, MSIZE1};

    reset = 1'b1; valid_e = 1'b0; dataE = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    tick(); tick();
    check("rst valid_m", 64'(valid_m), 64'd0);
    check("rst dreq_valid", 64'(dreq_valid), 64'd0);
    check("rst stall_m", 64'(stall_m), 64'd0);
    check("rst dataM", dataM.result, 64'd0);
    reset = 1'b0;
    tick();

    // Non-memory op: one-cycle pass-through, no bus activity.
    present(OP_NONE, 64'h0, 64'h1234);
    #1 check("add stall", 64'(stall_m), 64'd0);
    check("add dreq", 64'(dreq_valid), 64'd0);
    tick();
    valid_e = 1'b0;
    check("add valid_m", 64'(valid_m), 64'd1);
    check("add result", dataM.result, 64'h1234);
    check("add dst", 64'(dataM.dst), 64'd7);
    check("add dreq2", 64'(dreq_valid), 64'd0);
    tick();
    check("add pulse", 64'(valid_m), 64'd0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // SB with addr_ok delayed three cycles, then split data phase.
    present(OP_SB, 64'h1003, 64'hAB);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("sb hold valid", 64'(dreq_valid), 64'd1);
      check("sb hold addr", dreq_addr, 64'h1003);
      check("sb hold strobe", 64'(dreq_strobe), 64'h08);
      check("sb hold data", dreq_data, 64'hAB00_0000);
      check("sb hold size", 64'(dreq_size), 64'd0);
      check("sb hold stall", 64'(stall_m), 64'd1);
      check("sb hold valid_m", 64'(valid_m), 64'd0);
      tick();
    end
    dresp_addr_ok = 1'b1;
    #1 check("sb addr_ok stall", 64'(stall_m), 64'd1);
    tick();
    dresp_addr_ok = 1'b0;
    check("sb wait dreq", 64'(dreq_valid), 64'd0);
    check("sb wait stall", 64'(stall_m), 64'd1);
    tick();
    dresp_data_ok = 1'b1;
    dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 check("sb data_ok stall", 64'(stall_m), 64'd0);
    tick();
    dresp_data_ok = 1'b0;
    valid_e = 1'b0;
    check("sb valid_m", 64'(valid_m), 64'd1);
    check("sb result", dataM.result, 64'd0);
    check("sb regwrite", 64'(dataM.ctl.regwrite), 64'd0);
    tick();
    check("sb pulse", 64'(valid_m), 64'd0);

    // Reset while waiting for data: request dropped, late data_ok ignored.
    present(OP_LW, 64'h3004, 64'h0);
    tick();
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    check("rstw stall", 64'(stall_m), 64'd1);
    reset = 1'b1;
    valid_e = 1'b0;
    tick();
    reset = 1'b0;
    check("rstw stall_after", 64'(stall_m), 64'd0);
    check("rstw valid_m", 64'(valid_m), 64'd0);
    check("rstw dreq", 64'(dreq_valid), 64'd0);
    dresp_data_ok = 1'b1;
    dresp_data = 64'h8765_4321_0000_0000;
    tick();
    dresp_data_ok = 1'b0;
    check("rstw late valid_m", 64'(valid_m), 64'd0);
    tick();
    check("rstw late valid_m2", 64'(valid_m), 64'd0);

    // Misaligned doubleword.
    present(OP_LD, 64'h4004, 64'h0);
`ifdef MEM_MISALIGN_CHECK_EN
    #1 check("mis stall", 64'(stall_m), 64'd0);
    check("mis dreq", 64'(dreq_valid), 64'd0);
    tick();
    valid_e = 1'b0;
    check("mis valid_m", 64'(valid_m), 64'd1);
    check("mis flag", 64'(dataM.misalign), 64'd1);
    check("mis dreq2", 64'(dreq_valid), 64'd0);
    tick();
    check("mis pulse", 64'(valid_m), 64'd0);
`else
    #1 check("mis stall", 64'(stall_m), 64'd1);
    tick();
    check("mis dreq", 64'(dreq_valid), 64'd1);
    check("mis addr", dreq_addr, 64'h4004);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 64'h1111_2222_3333_4444;
    tick();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    valid_e = 1'b0;
    check("mis valid_m", 64'(valid_m), 64'd1);
    check("mis flag", 64'(dataM.misalign), 64'd0);
    check("mis result", dataM.result, 64'h0000_0000_1111_2222);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
